// File: rtl/syscall_input_engine_pkg.sv
// syscall_input_engine_pkg: shared states, codes, characters and byte-lane helpers
package syscall_input_engine_pkg;
  localparam int ADDR_W = 32;
  localparam logic [7:0] NL_CHAR = 8'h0A;
  localparam logic [7:0] CR_CHAR = 8'h0D;
  localparam logic [7:0] MINUS_CHAR = 8'h2D;
  localparam logic [31:0] SYS_READ_INT = 32'd5;
  localparam logic [31:0] SYS_READ_STR = 32'd8;
  typedef enum logic [2:0] {S_IDLE, S_INT_RX, S_STR_RX, S_TERM, S_FLUSH, S_DONE} state_t;
  // Big-endian lanes: lane 0 is bits [31:24]
  function automatic logic [31:0] lane_word(input logic [1:0] lane, input logic [7:0] b);
    return {b, 24'h0} >> {lane, 3'b000};
  endfunction
  function automatic logic [3:0] lane_be(input logic [1:0] lane);
    return 4'b1000 >> lane;
  endfunction
endpackage

// File: rtl/syscall_input_engine_word.sv
// syscall_word_packer: merges bytes into a pending word and issues registered word writes
module syscall_word_packer
  import syscall_input_engine_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              wr,
  input  logic              flush,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata
);
  logic [31:0] pend_data_q, pend_data_d, wdata_q, wdata_d, merged_data;
  logic [3:0] pend_be_q, pend_be_d, be_q, be_d, merged_be;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d, maddr_q, maddr_d, word_addr;
  logic we_q, we_d;
  always_comb begin
    word_addr = {addr[ADDR_W-1:2], 2'b00};
    merged_data = pend_data_q | lane_word(addr[1:0], data);
    merged_be = pend_be_q | lane_be(addr[1:0]);
    we_d = 1'b0;
    maddr_d = '0;
    be_d = '0;
    wdata_d = '0;
    pend_data_d = pend_data_q;
    pend_be_d = pend_be_q;
    pend_addr_d = pend_addr_q;
    if (clear) begin
      pend_data_d = '0;
      pend_be_d = '0;
    end else if (wr && addr[1:0] == 2'd3) begin
      we_d = 1'b1;
      maddr_d = word_addr;
      be_d = merged_be;
      wdata_d = merged_data;
      pend_data_d = '0;
      pend_be_d = '0;
    end else if (wr) begin
      pend_data_d = merged_data;
      pend_be_d = merged_be;
      pend_addr_d = word_addr;
    end else if (flush && pend_be_q != 4'b0000) begin
      we_d = 1'b1;
      maddr_d = pend_addr_q;
      be_d = pend_be_q;
      wdata_d = pend_data_q;
      pend_data_d = '0;
      pend_be_d = '0;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_data_q <= '0;
      pend_be_q <= '0;
      pend_addr_q <= '0;
      we_q <= 1'b0;
      maddr_q <= '0;
      be_q <= '0;
      wdata_q <= '0;
    end else begin
      pend_data_q <= pend_data_d;
      pend_be_q <= pend_be_d;
      pend_addr_q <= pend_addr_d;
      we_q <= we_d;
      maddr_q <= maddr_d;
      be_q <= be_d;
      wdata_q <= wdata_d;
    end
  end
  assign mem_we = we_q;
  assign mem_addr = maddr_q;
  assign mem_be = be_q;
  assign mem_wdata = wdata_q;
endmodule

// File: rtl/syscall_input_engine.sv
// syscall_input_engine: console read_int / read_string syscall responder fed from an RX byte stream
module syscall_input_engine
  import syscall_input_engine_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] buf_addr,
  input  logic [31:0]       max_len,
  output logic              busy,
  output logic              done,
  output logic [31:0]       int_result,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata
);
  state_t state_q, state_d;
  logic neg_q, neg_d, seen_q, seen_d;
  logic [31:0] acc_q, acc_d, res_q, res_d, rem_q, rem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic busy_q, done_q, ready_q;
  logic fire, is_nl, is_cr, is_dig, pk_clear, pk_wr, pk_flush;
  logic [7:0] pk_data;
  always_comb begin
    fire = rx_valid & ready_q;
    is_nl = rx_data == NL_CHAR;
    is_cr = rx_data == CR_CHAR;
    is_dig = rx_data >= 8'h30 && rx_data <= 8'h39;
    state_d = state_q;
    neg_d = neg_q;
    seen_d = seen_q;
    acc_d = acc_q;
    res_d = res_q;
    rem_d = rem_q;
    addr_d = addr_q;
    pk_clear = 1'b0;
    pk_wr = 1'b0;
    pk_flush = 1'b0;
    pk_data = rx_data;
    unique case (state_q)
      S_IDLE: if (start) begin
        pk_clear = 1'b1;
        neg_d = 1'b0;
        seen_d = 1'b0;
        acc_d = '0;
        addr_d = buf_addr;
        rem_d = max_len - 32'd1;
        state_d = !mode ? S_INT_RX : max_len == 32'd0 ? S_DONE : max_len == 32'd1 ? S_TERM : S_STR_RX;
      end
      S_INT_RX: if (fire && !is_cr) begin
        seen_d = 1'b1;
        if (is_nl) begin
          state_d = S_DONE;
          res_d = neg_q ? -acc_q : acc_q;
        end else if (rx_data == MINUS_CHAR && !seen_q) neg_d = 1'b1;
        else if (is_dig) acc_d = acc_q * 32'd10 + {28'h0, rx_data[3:0]};
      end
      S_STR_RX: if (fire && !is_cr) begin
        pk_wr = 1'b1;
        addr_d = addr_q + 1'b1;
        rem_d = rem_q - 32'd1;
        state_d = (is_nl || rem_q == 32'd1) ? S_TERM : S_STR_RX;
      end
      S_TERM: begin
        pk_wr = 1'b1;
        pk_data = 8'h00;
        state_d = S_FLUSH;
      end
      S_FLUSH: begin
        pk_flush = 1'b1;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      neg_q <= 1'b0;
      seen_q <= 1'b0;
      acc_q <= '0;
      res_q <= '0;
      rem_q <= '0;
      addr_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      neg_q <= neg_d;
      seen_q <= seen_d;
      acc_q <= acc_d;
      res_q <= res_d;
      rem_q <= rem_d;
      addr_q <= addr_d;
      busy_q <= state_d != S_IDLE;
      done_q <= state_d == S_DONE;
      ready_q <= state_d == S_INT_RX || state_d == S_STR_RX;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign rx_ready = ready_q;
  assign int_result = res_q;
  syscall_word_packer u_packer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (pk_clear),
    .wr        (pk_wr),
    .flush     (pk_flush),
    .addr      (addr_q),
    .data      (pk_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata)
  );
endmodule

// File: tb/tb_syscall_input_engine.sv
// tb_syscall_input_engine: table-driven directed checks of the input syscall engine
module tb_syscall_input_engine;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, mode = 1'b0, rx_valid = 1'b0;
  logic [31:0] buf_addr = '0, max_len = '0;
  logic [7:0] rx_data = '0;
  logic busy, done, rx_ready, mem_we;
  logic [31:0] int_result, mem_addr, mem_wdata;
  logic [3:0] mem_be;
  typedef struct packed {
    logic mode;
    logic [31:0] addr;
    logic [31:0] max_len;
    logic [95:0] s;
    int n;
    int take;
    int dc;
    logic [31:0] exp_int;
    int nwr;
    logic [31:0] wa0;
    logic [3:0] wb0;
    logic [31:0] wd0;
    logic [31:0] wa1;
    logic [3:0] wb1;
    logic [31:0] wd1;
  } vec_t;
  vec_t vecs[14];
  int checks = 0, errors = 0;
  int nwr, take, dcyc;
  logic got_done;
  logic [31:0] got_a[4], got_d[4];
  logic [3:0] got_b[4];

  syscall_input_engine dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .buf_addr(buf_addr),
    .max_len(max_len), .busy(busy), .done(done), .int_result(int_result),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int id);
    int idx = 0;
    logic [95:0] s = v.s;
    @(negedge clk);
    start = 1'b1;
    mode = v.mode;
    buf_addr = v.addr;
    max_len = v.max_len;
    rx_valid = 1'b0;
    nwr = 0;
    got_done = 1'b0;
    dcyc = 0;
    for (int c = 1; c <= 200 && !got_done; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1) chk($sformatf("v%0d busy_rise", id), {31'b0, busy}, 32'd1);
      if (mem_we) begin
        if (nwr < 4) begin
          got_a[nwr] = mem_addr;
          got_b[nwr] = mem_be;
          got_d[nwr] = mem_wdata;
        end
        nwr++;
      end
      if (done) begin
        got_done = 1'b1;
        dcyc = c;
      end
      rx_valid = idx < v.n;
      rx_data = idx < v.n ? s[8*(v.n-1-idx) +: 8] : 8'h00;
      if (rx_valid && rx_ready) idx++;
    end
    take = idx;
    @(negedge clk);
    chk($sformatf("v%0d busy_after_done", id), {31'b0, busy}, 32'd0);
    chk($sformatf("v%0d no_write_after_done", id), {31'b0, mem_we}, 32'd0);
    rx_valid = 1'b0;
    chk($sformatf("v%0d done_seen", id), {31'b0, got_done}, 32'd1);
    chk($sformatf("v%0d done_cycle", id), dcyc, v.dc);
    chk($sformatf("v%0d bytes_taken", id), take, v.take);
    chk($sformatf("v%0d writes", id), nwr, v.nwr);
    if (v.mode == 1'b0) chk($sformatf("v%0d int_result", id), int_result, v.exp_int);
    if (v.nwr >= 1 && nwr >= 1) begin
      chk($sformatf("v%0d w0_addr", id), got_a[0], v.wa0);
      chk($sformatf("v%0d w0_be", id), {28'b0, got_b[0]}, {28'b0, v.wb0});
      chk($sformatf("v%0d w0_data", id), got_d[0], v.wd0);
    end
    if (v.nwr >= 2 && nwr >= 2) begin
      chk($sformatf("v%0d w1_addr", id), got_a[1], v.wa1);
      chk($sformatf("v%0d w1_be", id), {28'b0, got_b[1]}, {28'b0, v.wb1});
      chk($sformatf("v%0d w1_data", id), got_d[1], v.wd1);
    end
  endtask

  initial begin
    vecs[0]  = '{mode:1'b0, addr:32'h0, max_len:32'h0, s:"-123\n", n:5, take:5, dc:6, exp_int:32'hFFFFFF85, nwr:0, wa0:0, wb0:0, wd0:0, wa1:0, wb1:0, wd1:0};
    vecs[1]  = '{mode:1'b0, addr:32'h0, max_len:32'h0, s:"4294967296\n", n:11, take:11, dc:12, exp_int:32'h0, nwr:0, wa0:0, wb0:0, wd0:0, wa1:0, wb1:0, wd1:0};
    vecs[2]  = '{mode:1'b0, addr:32'h0, max_len:32'h0, s:"7x8\n", n:4, take:4, dc:5, exp_int:32'd78, nwr:0, wa0:0, wb0:0, wd0:0, wa1:0, wb1:0, wd1:0};
    vecs[3]  = '{mode:1'b0, addr:32'h0, max_len:32'h0, s:"\n", n:1, take:1, dc:2, exp_int:32'h0, nwr:0, wa0:0, wb0:0, wd0:0, wa1:0, wb1:0, wd1:0};
    vecs[4]  = '{mode:1'b0, addr:32'h0, max_len:32'h0, s:"12-3\n", n:5, take:5, dc:6, exp_int:32'd123, nwr:0, wa0:0, wb0:0, wd0:0, wa1:0, wb1:0, wd1:0};
    vecs[5]  = '{mode:1'b0, addr:32'h0, max_len:32'h0, s:"\r-5\n", n:4, take:4, dc:5, exp_int:32'hFFFFFFFB, nwr:0, wa0:0, wb0:0, wd0:0, wa1:0, wb1:0, wd1:0};
    vecs[6]  = '{mode:1'b1, addr:32'h10000000, max_len:32'd8, s:"hi\n", n:3, take:3, dc:6, exp_int:0, nwr:1, wa0:32'h10000000, wb0:4'b1111, wd0:32'h68690A00, wa1:0, wb1:0, wd1:0};
    vecs[7]  = '{mode:1'b1, addr:32'h10000002, max_len:32'd8, s:"abc\n", n:4, take:4, dc:7, exp_int:0, nwr:2, wa0:32'h10000000, wb0:4'b0011, wd0:32'h00006162, wa1:32'h10000004, wb1:4'b1110, wd1:32'h630A0000};
    vecs[8]  = '{mode:1'b1, addr:32'h10000000, max_len:32'd4, s:"abcdef", n:6, take:3, dc:6, exp_int:0, nwr:1, wa0:32'h10000000, wb0:4'b1111, wd0:32'h61626300, wa1:0, wb1:0, wd1:0};
    vecs[9]  = '{mode:1'b1, addr:32'h10000000, max_len:32'd0, s:"xy", n:2, take:0, dc:1, exp_int:0, nwr:0, wa0:0, wb0:0, wd0:0, wa1:0, wb1:0, wd1:0};
    vecs[10] = '{mode:1'b1, addr:32'h20000001, max_len:32'd1, s:"z", n:1, take:0, dc:3, exp_int:0, nwr:1, wa0:32'h20000000, wb0:4'b0100, wd0:32'h0, wa1:0, wb1:0, wd1:0};
    vecs[11] = '{mode:1'b1, addr:32'h00000100, max_len:32'd8, s:"a\rb\n", n:4, take:4, dc:7, exp_int:0, nwr:1, wa0:32'h00000100, wb0:4'b1111, wd0:32'h61620A00, wa1:0, wb1:0, wd1:0};
    vecs[12] = '{mode:1'b1, addr:32'hFFFFFFFE, max_len:32'd8, s:"ab\n", n:3, take:3, dc:6, exp_int:0, nwr:2, wa0:32'hFFFFFFFC, wb0:4'b0011, wd0:32'h00006162, wa1:32'h0, wb1:4'b1100, wd1:32'h0A000000};
    vecs[13] = '{mode:1'b1, addr:32'h10000000, max_len:32'd8, s:"hi\n", n:3, take:3, dc:6, exp_int:0, nwr:1, wa0:32'h10000000, wb0:4'b1111, wd0:32'h68690A00, wa1:0, wb1:0, wd1:0};
    #1;
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset rx_ready", {31'b0, rx_ready}, 32'd0);
    chk("reset mem_we", {31'b0, mem_we}, 32'd0);
    chk("reset int_result", int_result, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 13; i++) run(vecs[i], i);
    // Reset in the middle of a string read: partial word is dropped
    @(negedge clk);
    start = 1'b1;
    mode = 1'b1;
    buf_addr = 32'h10000000;
    max_len = 32'd8;
    @(negedge clk);
    start = 1'b0;
    rx_valid = 1'b1;
    rx_data = 8'h61;
    chk("mid rx_ready", {31'b0, rx_ready}, 32'd1);
    @(negedge clk);
    rx_data = 8'h62;
    chk("mid mem_we1", {31'b0, mem_we}, 32'd0);
    @(negedge clk);
    rx_valid = 1'b0;
    chk("mid mem_we2", {31'b0, mem_we}, 32'd0);
    chk("mid busy", {31'b0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst done", {31'b0, done}, 32'd0);
    chk("rst rx_ready", {31'b0, rx_ready}, 32'd0);
    chk("rst mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_be", {28'b0, mem_be}, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst int_result", int_result, 32'd0);
    @(negedge clk);
    chk("rst hold mem_we", {31'b0, mem_we}, 32'd0);
    reset_n = 1'b1;
    run(vecs[13], 13);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
